// File: rtl/mmio_timer_pkg.sv
// Shared types and register map for the mmio_timer peripheral and its lane-merge helper.
package mmio_timer_pkg;

  typedef enum logic [2:0] {
    MEM_DT_BYTE  = 3'd0,
    MEM_DT_UBYTE = 3'd1,
    MEM_DT_HALF  = 3'd2,
    MEM_DT_UHALF = 3'd3,
    MEM_DT_WORD  = 3'd4
  } mem_dt_e;

  typedef enum logic [0:0] {
    ENOERR = 1'b0,
    EALIGN = 1'b1
  } errno_e;

  localparam logic [4:0] MMIO_TIMER_CTRL_OFF   = 5'h00;
  localparam logic [4:0] MMIO_TIMER_PRESC_OFF  = 5'h04;
  localparam logic [4:0] MMIO_TIMER_COUNT_OFF  = 5'h08;
  localparam logic [4:0] MMIO_TIMER_CMP_OFF    = 5'h0C;
  localparam logic [4:0] MMIO_TIMER_STATUS_OFF = 5'h10;
  localparam logic [4:0] MMIO_TIMER_COUNTH_OFF = 5'h14;

  localparam int MMIO_TIMER_CTRL_EN_BIT          = 0;
  localparam int MMIO_TIMER_CTRL_AUTO_RELOAD_BIT = 1;
  localparam int MMIO_TIMER_CTRL_IRQ_EN_BIT      = 2;
  localparam int MMIO_TIMER_STATUS_MATCH_BIT     = 0;

  // Half accesses need an even address, word accesses a 4-byte aligned one.
  function automatic logic dt_misaligned(input mem_dt_e dt, input logic [1:0] lane);
    logic mis;
    case (dt)
      MEM_DT_HALF, MEM_DT_UHALF: mis = lane[0];
      MEM_DT_WORD:               mis = (lane != 2'b00);
      default:                   mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mmio_lane_merge.sv
// Byte/half lane extraction with sign/zero extension, and store-data merge into a 32-bit register.
module mmio_lane_merge
  import mmio_timer_pkg::*;
(
  input  mem_dt_e     dt_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] reg_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o,
  output logic [31:0] wr_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = reg_i[{lane_i, 3'b000} +: 8];
  assign half_s = lane_i[1] ? reg_i[31:16] : reg_i[15:0];

  // Load extraction and store merge for the addressed lanes.
  always_comb begin
    rd_o = 32'd0;
    wr_o = reg_i;
    case (dt_i)
      MEM_DT_BYTE, MEM_DT_UBYTE: begin
        rd_o = (dt_i == MEM_DT_BYTE) ? {{24{byte_s[7]}}, byte_s} : {24'd0, byte_s};
        wr_o[{lane_i, 3'b000} +: 8] = wd_i[7:0];
      end
      MEM_DT_HALF, MEM_DT_UHALF: begin
        rd_o = (dt_i == MEM_DT_HALF) ? {{16{half_s[15]}}, half_s} : {16'd0, half_s};
        if (lane_i[1]) begin
          wr_o[31:16] = wd_i[15:0];
        end else begin
          wr_o[15:0] = wd_i[15:0];
        end
      end
      MEM_DT_WORD: begin
        rd_o = reg_i;
        wr_o = wd_i;
      end
      default: begin
        rd_o = 32'd0;
        wr_o = reg_i;
      end
    endcase
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled up-counter with compare, sticky MATCH and registered irq.
// Optional macro MMIO_TIMER_COUNT64_EN widens COUNT to 64 bits with a COUNTH shadow at 0x14.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
  parameter logic [31:0] RST_PRESC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic        d_we,
  input  logic [31:0] d_wd,
  input  mem_dt_e     d_dt,
  output logic [31:0] d_rd,
  output errno_e      err,
  output logic        sel,
  output logic        irq
);

`ifdef MMIO_TIMER_COUNT64_EN
  localparam int CW = 64;
  logic [31:0] counth_q, counth_d;
`else
  localparam int CW = 32;
`endif

  logic [2:0]    ctrl_q, ctrl_d;
  logic [31:0]   presc_q, presc_d;
  logic [31:0]   psc_q, psc_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   cmp_q, cmp_d;
  logic          match_q, match_d;
  logic          irq_q, irq_d;

  logic [4:0]  word_off_s;
  logic        misal_s, wr_en_s, tick_s, hit_s;
  logic [31:0] reg_rd_s, lane_rd_s, wr_data_s;

  assign sel        = (d_addr[31:5] == BASE_ADDR[31:5]);
  assign word_off_s = {d_addr[4:2], 2'b00};
  assign misal_s    = dt_misaligned(d_dt, d_addr[1:0]);
  assign wr_en_s    = d_we & sel & ~misal_s;
  assign err        = (sel & misal_s) ? EALIGN : ENOERR;
  assign d_rd       = (sel & ~misal_s) ? lane_rd_s : 32'd0;
  assign irq        = irq_q;

  // Full 32-bit view of the addressed register.
  always_comb begin
    reg_rd_s = 32'd0;
    case (word_off_s)
      MMIO_TIMER_CTRL_OFF:   reg_rd_s = {29'd0, ctrl_q};
      MMIO_TIMER_PRESC_OFF:  reg_rd_s = presc_q;
      MMIO_TIMER_COUNT_OFF:  reg_rd_s = count_q[31:0];
      MMIO_TIMER_CMP_OFF:    reg_rd_s = cmp_q;
      MMIO_TIMER_STATUS_OFF: reg_rd_s = {31'd0, match_q};
`ifdef MMIO_TIMER_COUNT64_EN
      MMIO_TIMER_COUNTH_OFF: reg_rd_s = counth_q;
`endif
      default:               reg_rd_s = 32'd0;
    endcase
  end

  mmio_lane_merge u_lane (
    .dt_i   (d_dt),
    .lane_i (d_addr[1:0]),
    .reg_i  (reg_rd_s),
    .wd_i   (d_wd),
    .rd_o   (lane_rd_s),
    .wr_o   (wr_data_s)
  );

  assign tick_s = ctrl_q[MMIO_TIMER_CTRL_EN_BIT] & (psc_q == presc_q);
  assign hit_s  = (count_q[31:0] == cmp_q);

  // Next-state: software writes take priority over tick updates of COUNT.
  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    cmp_d   = cmp_q;
    count_d = count_q;
    psc_d   = psc_q;
    if (wr_en_s && word_off_s == MMIO_TIMER_CTRL_OFF) begin
      ctrl_d = wr_data_s[2:0];
    end else begin
      ctrl_d = ctrl_q;
    end
    if (wr_en_s && word_off_s == MMIO_TIMER_PRESC_OFF) begin
      presc_d = wr_data_s;
      psc_d   = 32'd0;
    end else if (tick_s) begin
      psc_d = 32'd0;
    end else if (ctrl_q[MMIO_TIMER_CTRL_EN_BIT]) begin
      psc_d = psc_q + 32'd1;
    end else begin
      psc_d = psc_q;
    end
    if (wr_en_s && word_off_s == MMIO_TIMER_CMP_OFF) begin
      cmp_d = wr_data_s;
    end else begin
      cmp_d = cmp_q;
    end
    if (wr_en_s && word_off_s == MMIO_TIMER_COUNT_OFF) begin
      count_d = CW'(wr_data_s);
    end else if (tick_s && hit_s && ctrl_q[MMIO_TIMER_CTRL_AUTO_RELOAD_BIT]) begin
      count_d = '0;
    end else if (tick_s) begin
      count_d = count_q + CW'(32'd1);
    end else begin
      count_d = count_q;
    end
    // W1C only counts when byte lane 0 (which holds MATCH) is actually written; set wins.
    match_d = (tick_s & hit_s & ~(wr_en_s && word_off_s == MMIO_TIMER_COUNT_OFF)) |
              (match_q & ~(wr_en_s && word_off_s == MMIO_TIMER_STATUS_OFF &&
                           d_addr[1:0] == 2'b00 && d_wd[MMIO_TIMER_STATUS_MATCH_BIT]));
    irq_d = match_q & ctrl_q[MMIO_TIMER_CTRL_IRQ_EN_BIT];
`ifdef MMIO_TIMER_COUNT64_EN
    if (sel && !d_we && !misal_s && d_dt == MEM_DT_WORD && word_off_s == MMIO_TIMER_COUNT_OFF) begin
      counth_d = count_q[63:32];
    end else begin
      counth_d = counth_q;
    end
`endif
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= 3'd0;
      presc_q  <= RST_PRESC;
      psc_q    <= 32'd0;
      count_q  <= '0;
      cmp_q    <= 32'hFFFF_FFFF;
      match_q  <= 1'b0;
      irq_q    <= 1'b0;
`ifdef MMIO_TIMER_COUNT64_EN
      counth_q <= 32'd0;
`endif
    end else begin
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      psc_q    <= psc_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      match_q  <= match_d;
      irq_q    <= irq_d;
`ifdef MMIO_TIMER_COUNT64_EN
      counth_q <= counth_d;
`endif
    end
  end

endmodule
